// File: rtl/car_detect_pkg.sv
// Shared types and constants for the CarDetection frame sequencer.
package car_detect_pkg;

    localparam int CONF_W = 44;

    localparam logic [CONF_W-1:0] SVM_BIAS_RESET = 44'hFFFC3C55080;

    localparam logic [3:0] ALARM_OK       = 4'd0;
    localparam logic [3:0] ALARM_UNDERRUN = 4'd1;
    localparam logic [3:0] ALARM_OVERRUN  = 4'd2;
    localparam logic [3:0] ALARM_WATCHDOG = 4'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        PUBLISH = 2'd3
    } state_e;

endpackage

// File: rtl/win_grid_tracker.sv
// Maps each scored window to its grid column/row in raster order and keeps
// the strongest above-threshold window seen so far in the frame.
module win_grid_tracker
    import car_detect_pkg::*;
#(
    parameter int COLS = 3,
    parameter int NWIN = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     valid_i,
    input  logic signed [CONF_W-1:0] conf_i,
    input  logic signed [CONF_W-1:0] thr_i,
    output logic [15:0]              best_col_o,
    output logic [15:0]              best_row_o,
    output logic                     hit_o,
    output logic [31:0]              idx_o
);

    localparam logic [15:0] COL_LAST = 16'(COLS - 1);
    localparam logic [31:0] NWIN_U   = 32'(NWIN);

    logic [15:0]              col_q, col_d, row_q, row_d;
    logic [15:0]              bcol_q, bcol_d, brow_q, brow_d;
    logic [31:0]              idx_q, idx_d;
    logic                     hit_q, hit_d;
    logic signed [CONF_W-1:0] best_q, best_d;
    logic                     better;

    always_comb begin
        // Strict compare keeps the earlier window on equal scores.
        better = (conf_i > thr_i) && (!hit_q || (conf_i > best_q));
        col_d  = col_q;
        row_d  = row_q;
        idx_d  = idx_q;
        bcol_d = bcol_q;
        brow_d = brow_q;
        hit_d  = hit_q;
        best_d = best_q;
        if (clr_i) begin
            col_d  = '0;
            row_d  = '0;
            idx_d  = '0;
            bcol_d = '0;
            brow_d = '0;
            hit_d  = 1'b0;
            best_d = '0;
        end else if (valid_i) begin
            if ((idx_q < NWIN_U) && better) begin
                best_d = conf_i;
                bcol_d = col_q;
                brow_d = row_q;
                hit_d  = 1'b1;
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
            // Saturating at NWIN+1 is enough to tell overrun from a full frame.
            if (idx_q <= NWIN_U) begin
                idx_d = idx_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q  <= '0;
            row_q  <= '0;
            idx_q  <= '0;
            bcol_q <= '0;
            brow_q <= '0;
            hit_q  <= 1'b0;
            best_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            idx_q  <= idx_d;
            bcol_q <= bcol_d;
            brow_q <= brow_d;
            hit_q  <= hit_d;
            best_q <= best_d;
        end
    end

    assign best_col_o = bcol_q;
    assign best_row_o = brow_q;
    assign hit_o      = hit_q;
    assign idx_o      = idx_q;

endmodule

// File: rtl/car_detect_frame_ctrl.sv
// Frame-level sequencer beside CarDetection: arms on frame boundaries, shadows
// svm_bias, publishes the best window per frame and watches for a stalled source.
module car_detect_frame_ctrl
    import car_detect_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int WIN_W     = 64,
    parameter int WIN_H     = 64,
    parameter int STRIDE    = 8,
    parameter int WD_CYCLES = 2000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     vsync_in,
    input  logic signed [CONF_W-1:0] confidence,
    input  logic                     confidence_valid,
    input  logic signed [CONF_W-1:0] threshold,
    input  logic [CONF_W-1:0]        bias_in,
    input  logic                     bias_wr,
    output logic [CONF_W-1:0]        svm_bias,
    output logic                     busy,
    output logic [15:0]              bbox_x_start,
    output logic [15:0]              bbox_y_start,
    output logic [15:0]              bbox_x_end,
    output logic [15:0]              bbox_y_end,
    output logic                     bbox_valid,
    output logic                     done,
    output logic [3:0]               alarm_code
);

    localparam int COLS = (H_ACTIVE - WIN_W) / STRIDE + 1;
    localparam int ROWS = (V_ACTIVE - WIN_H) / STRIDE + 1;
    localparam int NWIN = COLS * ROWS;

    localparam logic [15:0] STRIDE_U = 16'(STRIDE);
    localparam logic [15:0] WIN_W_M1 = 16'(WIN_W - 1);
    localparam logic [15:0] WIN_H_M1 = 16'(WIN_H - 1);
    localparam logic [31:0] NWIN_U   = 32'(NWIN);
    localparam logic [31:0] WD_LAST  = 32'(WD_CYCLES - 1);

    state_e              state_q, state_d;
    logic                vs_q, vs_prev_q, fb;
    logic [31:0]         wd_q, wd_d;
    logic                wd_trip, load, publish;
    logic [CONF_W-1:0]   shadow_q, svm_bias_q;
    logic [15:0]         bx_start_q, by_start_q, bx_end_q, by_end_q;
    logic                bbox_valid_q, done_q;
    logic [3:0]          alarm_q;
    logic [15:0]         best_col, best_row, bx_start, by_start;
    logic                hit;
    logic [31:0]         idx;

    assign fb = vs_q & ~vs_prev_q;

    // A boundary in the same cycle counts as progress, so it pre-empts the trip.
    assign wd_trip = (state_q != IDLE) && !fb && (wd_q == WD_LAST);

    always_comb begin
        wd_d = wd_q + 32'd1;
        if ((state_q == IDLE) || fb || wd_trip) begin
            wd_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        publish = 1'b0;
        if (wd_trip) begin
            state_d = WAIT_VS;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = WAIT_VS;
                WAIT_VS: if (fb) begin
                    if (enable) begin
                        state_d = ACTIVE;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACTIVE:  if (fb) state_d = PUBLISH;
                PUBLISH: begin
                    publish = 1'b1;
                    // The boundary that closed this frame already opened the next one.
                    if (enable) begin
                        state_d = ACTIVE;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    win_grid_tracker #(
        .COLS (COLS),
        .NWIN (NWIN)
    ) u_tracker (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clr_i      (load),
        .valid_i    (confidence_valid && (state_q == ACTIVE)),
        .conf_i     (confidence),
        .thr_i      (threshold),
        .best_col_o (best_col),
        .best_row_o (best_row),
        .hit_o      (hit),
        .idx_o      (idx)
    );

    assign bx_start = best_col * STRIDE_U;
    assign by_start = best_row * STRIDE_U;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            vs_q         <= 1'b0;
            vs_prev_q    <= 1'b0;
            wd_q         <= '0;
            shadow_q     <= SVM_BIAS_RESET;
            svm_bias_q   <= SVM_BIAS_RESET;
            bx_start_q   <= '0;
            by_start_q   <= '0;
            bx_end_q     <= '0;
            by_end_q     <= '0;
            bbox_valid_q <= 1'b0;
            done_q       <= 1'b0;
            alarm_q      <= ALARM_OK;
        end else begin
            state_q   <= state_d;
            vs_q      <= vsync_in;
            vs_prev_q <= vs_q;
            wd_q      <= wd_d;
            done_q    <= publish | wd_trip;
            if (bias_wr) shadow_q <= bias_in;
            // Nonblocking read gives the pre-write shadow on a coincident bias_wr.
            if (load) svm_bias_q <= shadow_q;
            if (wd_trip) begin
                bbox_valid_q <= 1'b0;
                alarm_q      <= ALARM_WATCHDOG;
            end else if (publish) begin
                bx_start_q   <= bx_start;
                by_start_q   <= by_start;
                bx_end_q     <= bx_start + WIN_W_M1;
                by_end_q     <= by_start + WIN_H_M1;
                bbox_valid_q <= hit;
                if (idx == NWIN_U)     alarm_q <= ALARM_OK;
                else if (idx < NWIN_U) alarm_q <= ALARM_UNDERRUN;
                else                   alarm_q <= ALARM_OVERRUN;
            end
        end
    end

    assign svm_bias     = svm_bias_q;
    assign busy         = (state_q == ACTIVE);
    assign bbox_x_start = bx_start_q;
    assign bbox_y_start = by_start_q;
    assign bbox_x_end   = bx_end_q;
    assign bbox_y_end   = by_end_q;
    assign bbox_valid   = bbox_valid_q;
    assign done         = done_q;
    assign alarm_code   = alarm_q;

endmodule

// File: doc/car_detect_frame_ctrl.md
Name: car_detect_frame_ctrl

Overview:
- Frame-level sequencer placed beside CarDetection, in the hdmi_clk domain.
- Arms detection only on a frame boundary and applies svm_bias updates at frame boundaries only (shadow register).
- Counts confidence_valid results and maps each one to a sliding-window grid position; tracks the strongest window above threshold.
- At each frame end it publishes the bbox, a done pulse and an alarm_code; a watchdog catches a stalled video source.

Parameters:
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.
- WIN_W, 64: detection window width, in pixels.
- WIN_H, 64: detection window height, in pixels.
- STRIDE, 8: window step in x and y, in pixels.
- WD_CYCLES, 2000000: watchdog limit, in clk cycles between vsync rising edges.

Ports:
- clk  in  1  pixel clock (hdmi_clk)
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request; sampled only at frame boundaries
- vsync_in  in  1  delayed vsync feeding CarDetection; active-high
- confidence  in  44  signed SVM score from CarDetection
- confidence_valid  in  1  one score per window, windows in raster order
- threshold  in  44  signed detection threshold
- bias_in  in  44  new svm_bias value
- bias_wr  in  1  one-cycle strobe; captures bias_in into the shadow register
- svm_bias  out  44  bias driven to CarDetection; updated only at frame start
- busy  out  1  high in ACTIVE state
- bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end  out  16 each  published box
- bbox_valid  out  1  high when the last published frame had a hit
- done  out  1  one-cycle pulse per published frame
- alarm_code  out  4  status of the last published frame

Behaviour:
- Reset values: all outputs 0; svm_bias = 44'hFFFC3C55080; shadow register = same value; state = IDLE.
- Derived constants: COLS = (H_ACTIVE-WIN_W)/STRIDE+1; ROWS = (V_ACTIVE-WIN_H)/STRIDE+1; NWIN = COLS*ROWS.
- Frame boundary (fb): vsync_in registered once; fb = rising edge of the registered signal.
- IDLE: if enable=1 go to WAIT_VS.
- WAIT_VS:
  - on fb with enable=1: load svm_bias from shadow, clear col/row/idx counters and best-score tracker, go to ACTIVE;
  - on fb with enable=0: go to IDLE.
- ACTIVE, on each confidence_valid:
  - if idx < NWIN: if confidence > threshold (signed compare) and confidence > best (or no hit yet), store score, col and row;
  - advance col; wrap to 0 at COLS and increment row;
  - idx saturates at NWIN+1.
- ACTIVE on fb: go to PUBLISH. The valid sample in this same cycle is counted before the transition.
- PUBLISH (1 cycle):
  - bbox_x_start = col*STRIDE; bbox_x_end = col*STRIDE+WIN_W-1;
  - bbox_y_start = row*STRIDE; bbox_y_end = row*STRIDE+WIN_H-1;
  - bbox_valid = hit flag;
  - done = 1 for this cycle;
  - alarm_code: 0 if idx==NWIN; 1 if idx<NWIN (underrun); 2 if idx>NWIN (overrun).
  - Then, if enable=1: load svm_bias, clear the tracker, go to ACTIVE; this frame's fb starts the next frame and no frame is skipped. If enable=0, go to IDLE.
- bbox outputs and bbox_valid hold until the next PUBLISH.
- enable deasserted mid-frame: the current frame completes and publishes.
- Ties: on equal scores the earlier window is kept (strict >).
- bias_wr: when it coincides with a frame load, svm_bias takes the old shadow value; the new value applies from the next frame.
- Watchdog: counts cycles since the last fb whenever state ≠ IDLE. On reaching WD_CYCLES:
  - alarm_code = 4, done pulses once, bbox_valid = 0;
  - state goes to WAIT_VS.
- Reset mid-frame: all state returns immediately to reset values; no done pulse is issued.
- Arithmetic: col*STRIDE is computed in 16 bits unsigned; parameters must satisfy H_ACTIVE, V_ACTIVE < 65536.

Decomposition:
- Package car_detect_pkg holds:
  - state enum (IDLE, WAIT_VS, ACTIVE, PUBLISH);
  - alarm constants ALARM_OK=0, ALARM_UNDERRUN=1, ALARM_OVERRUN=2, ALARM_WATCHDOG=4;
  - SVM_BIAS_RESET = 44'hFFFC3C55080;
  - CONF_W = 44.
- One sub-module, win_grid_tracker: col/row/idx counters plus the best-score compare and store. The FSM, watchdog and bias shadow stay at top level.

Test Plan:
All scenarios use H_ACTIVE=32, V_ACTIVE=24, WIN=16, STRIDE=8, which gives COLS=3, ROWS=2, NWIN=6.
- Reset, enable=1, two vsync pulses, 6 valids with scores {-5,3,9,2,9,1}, threshold=0 -> done at the 2nd fb+2 cycles; bbox (16,0)-(31,15); bbox_valid=1; alarm 0 (tie keeps idx 2).
- Same setup, all scores ≤ threshold -> done pulse, bbox_valid=0, alarm 0.
- 5 valids -> alarm 1; 8 valids -> alarm 2; bbox is chosen from the first 6 only.
- bias_wr with 44'h00000000123 mid-frame -> svm_bias unchanged until the next fb, then equals 44'h123; bias_wr in the fb cycle -> change lands one frame later.
- Set WD_CYCLES=100, no vsync after arming -> done at cycle 100 with alarm 4; a later fb restarts normally.
- Assert reset low mid-ACTIVE -> outputs are 0 and svm_bias = 44'hFFFC3C55080 asynchronously; no done pulse.
